// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, issues one outstanding imem read at a time,
// and buffers returned words with their PC for decode. A redirect flushes the stage.
module instruction_fetch #(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [31:0]         if_instruction
);

    localparam int unsigned INSN_W = 32;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } entry_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [FIFO_DEPTH];
    logic               req_valid_q, req_valid_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic               if_valid_q, if_valid_d;
    entry_t             head_q, head_d;

    logic               hs;
    logic               push;
    logic               pop;
    entry_t             push_entry;
    logic               unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Next-state for the fetch FSM, FIFO bookkeeping and registered outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        head_d      = head_q;

        hs          = (state_q == S_FETCH) && req_valid_q && imem_req_ready;
        push        = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
        pop         = if_valid_q && if_ready && !redirect_valid;
        push_entry  = '{pc: req_pc_q, insn: imem_rsp_data};

        case (state_q)
            S_FETCH: begin
                if (hs) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect wins over everything; a request already in flight becomes stale.
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            case (state_q)
                S_FETCH: state_d = hs ? S_DRAIN : S_FETCH;
                default: state_d = imem_rsp_valid ? S_FETCH : S_DRAIN;
            endcase
        end

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            head_d  = (push && (rd_ptr_d == wr_ptr_q)) ? push_entry : mem_q[rd_ptr_d];
        end

        req_valid_d = (state_d == S_FETCH) && (count_d < CNT_W'(FIFO_DEPTH));
        addr_d      = pc_d;
        if_valid_d  = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= RESET_PC;
            if_valid_q  <= 1'b0;
            head_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            if_valid_q  <= if_valid_d;
            head_q      <= head_d;
        end
    end

    // FIFO storage; head is mirrored into head_q so if_* come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = addr_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = head_q.pc;
    assign if_instruction = head_q.insn;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle table for streaming/backpressure,
// plus hand sequences for redirect, alignment, wrap and reset corner cases.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    int nvec = 0;
    int nerr = 0;
    int mem_lat = 1;

    instruction_fetch #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: answers each accepted request exactly mem_lat cycles later.
    logic        hs_next = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;

    always @(negedge clk) begin
        hs_next  = imem_req_valid && imem_req_ready;
        cap_addr = imem_addr;
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        if (hs_next) begin
            pend_addr = cap_addr;
            cnt       = mem_lat;
        end
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word(pend_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_insn", if_instruction, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    vec_t tv [22];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with k=1, then 10 cycles of backpressure and release.
        tv[0]  = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 1'b0, 32'h104, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
        tv[4]  = '{1'b1, 1'b0, 32'h108, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tv[6]  = '{1'b1, 1'b0, 32'h10C, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};
        tv[8]  = '{1'b0, 1'b0, 32'h110, 1'b0, 32'h0};
        tv[9]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h10C};
        tv[10] = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C};
        for (int i = 11; i <= 17; i++) begin
            tv[i] = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C};
        end
        tv[18] = '{1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
        tv[19] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h110};
        tv[20] = '{1'b1, 1'b0, 32'h118, 1'b0, 32'h0};
        tv[21] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h114};

        mem_lat = 1;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            chk($sformatf("tbl%0d_req_valid", c), 32'(imem_req_valid), 32'(tv[c].rv));
            chk($sformatf("tbl%0d_addr", c), imem_addr, tv[c].addr);
            chk($sformatf("tbl%0d_if_valid", c), 32'(if_valid), 32'(tv[c].iv));
            if (tv[c].iv) begin
                chk($sformatf("tbl%0d_if_pc", c), if_pc, tv[c].pc);
                chk($sformatf("tbl%0d_if_insn", c), if_instruction, word(tv[c].pc));
            end
            if_ready = tv[c].rdy;
            tick();
        end

        // Redirect while waiting on a slow (k=3) response.
        begin
            int n;
            mem_lat = 3;
            do_reset();
            tick();
            tick();
            chk("t3_wait_req_valid", 32'(imem_req_valid), 32'd0);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h2000;
            tick();
            redirect_valid = 1'b0;
            chk("t3_drain_req_valid", 32'(imem_req_valid), 32'd0);
            chk("t3_drain_addr", imem_addr, 32'h2000);
            chk("t3_drain_if_valid", 32'(if_valid), 32'd0);
            tick();
            chk("t3_drain2_if_valid", 32'(if_valid), 32'd0);
            tick();
            chk("t3_fetch_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_fetch_addr", imem_addr, 32'h2000);
            chk("t3_fetch_if_valid", 32'(if_valid), 32'd0);
            n = 0;
            while (!if_valid && n < 12) begin
                tick();
                n++;
            end
            chk("t3_latency", 32'(n), 32'd4);
            chk("t3_if_pc", if_pc, 32'h2000);
            chk("t3_if_insn", if_instruction, word(32'h2000));
        end

        // Redirect coincident with a response and a pop of the FIFO head.
        mem_lat = 1;
        do_reset();
        if_ready = 1'b0;
        repeat (3) tick();
        chk("t4_head_valid", 32'(if_valid), 32'd1);
        chk("t4_head_pc", if_pc, 32'h100);
        tick();
        chk("t4_wait_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t4_wait_head_pc", if_pc, 32'h100);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000;
        tick();
        redirect_valid = 1'b0;
        chk("t4_flush_if_valid", 32'(if_valid), 32'd0);
        chk("t4_flush_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_flush_addr", imem_addr, 32'h4000);
        tick();
        chk("t4_next_if_valid", 32'(if_valid), 32'd0);
        chk("t4_next_addr", imem_addr, 32'h4004);
        tick();
        chk("t4_tgt_if_valid", 32'(if_valid), 32'd1);
        chk("t4_tgt_if_pc", if_pc, 32'h4000);
        chk("t4_tgt_if_insn", if_instruction, word(32'h4000));

        // Misaligned redirect during an accepted handshake, then PC wrap.
        do_reset();
        tick();
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3003;
        tick();
        redirect_valid = 1'b0;
        chk("t5_drain_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t5_drain_addr", imem_addr, 32'h3000);
        tick();
        chk("t5_fetch_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_fetch_addr", imem_addr, 32'h3000);
        chk("t5_fetch_if_valid", 32'(if_valid), 32'd0);
        tick();
        chk("t5_wait_addr", imem_addr, 32'h3004);
        tick();
        chk("t5_if_valid", 32'(if_valid), 32'd1);
        chk("t5_if_pc", if_pc, 32'h3000);

        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("t5w_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t5w_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5w_wrap_addr", imem_addr, 32'h0);
        tick();
        chk("t5w_if_valid", 32'(if_valid), 32'd1);
        chk("t5w_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5w_if_insn", if_instruction, word(32'hFFFF_FFFC));
        chk("t5w_next_addr", imem_addr, 32'h0);

        // Reset asserted mid-WAIT; the late response lands in FETCH and is ignored.
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_addr", imem_addr, 32'h100);
        chk("t6_rst_if_valid", 32'(if_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("t6_rel_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_addr, 32'h100);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t6_late%0d_if_valid", c), 32'(if_valid), 32'd0);
        end
        tick();
        chk("t6_if_valid", 32'(if_valid), 32'd1);
        chk("t6_if_pc", if_pc, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
